// File: rtl/riscv_dmem_lsu_ram.sv
// ============================================================================
// Module   : riscv_dmem_lsu_ram
// Brief    : RV32 data memory with byte/half/word load-store, 1-2 cycle
//            response pipeline and optional post-reset zero sweep.
// Revision : 1.0
// ============================================================================
`default_nettype none

module riscv_dmem_lsu_ram #(
  parameter int AW         = 7,
  parameter int LAT        = 1,
  parameter int INIT_CLEAR = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [AW+1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err
);

  localparam int            c_DEPTH    = 1 << AW;
  localparam logic          c_ST_CLEAR = 1'b0;
  localparam logic          c_ST_RUN   = 1'b1;
  localparam logic [1:0]    c_SZ_BYTE  = 2'b00;
  localparam logic [1:0]    c_SZ_HALF  = 2'b01;
  localparam logic [1:0]    c_SZ_WORD  = 2'b10;
  localparam logic [AW-1:0] c_CLR_LAST = '1;

  logic          r_state;
  logic          w_state_nxt;
  logic [AW-1:0] r_clr_cnt;
  logic          w_clearing;

  // ---------------------------------------------------------------- control FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= (INIT_CLEAR != 0) ? c_ST_CLEAR : c_ST_RUN;
      r_clr_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_clearing) begin
        r_clr_cnt <= r_clr_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if ((r_state == c_ST_CLEAR) && (r_clr_cnt == c_CLR_LAST)) begin
      w_state_nxt = c_ST_RUN;
    end
  end

  // Gating with rst_n keeps ready low during reset even when reset lands in RUN.
  always_comb begin
    req_ready  = rst_n && (r_state == c_ST_RUN);
    w_clearing = (r_state == c_ST_CLEAR);
  end

  // ------------------------------------------------------------- request decode
  logic          w_accept;
  logic [AW-1:0] w_idx;
  logic [1:0]    w_off;
  logic          w_misal;
  logic [3:0]    w_strb;
  logic [31:0]   w_wdata_rep;

  always_comb begin
    w_accept    = req_valid && req_ready;
    w_idx       = req_addr[AW+1:2];
    w_off       = req_addr[1:0];
    w_misal     = 1'b0;
    w_strb      = 4'b0000;
    w_wdata_rep = req_wdata;
    case (req_size)
      c_SZ_BYTE: begin
        w_strb      = 4'b0001 << w_off;
        w_wdata_rep = {4{req_wdata[7:0]}};
      end
      c_SZ_HALF: begin
        w_misal     = w_off[0];
        w_strb      = w_off[1] ? 4'b1100 : 4'b0011;
        w_wdata_rep = {2{req_wdata[15:0]}};
      end
      c_SZ_WORD: begin
        w_misal = (w_off != 2'b00);
        w_strb  = 4'b1111;
      end
      default: w_misal = 1'b1;
    endcase
  end

  // ------------------------------------------------------------- storage array
  logic [31:0]   r_mem [c_DEPTH];
  logic [31:0]   r_rd_word;
  logic          w_mem_we;
  logic [AW-1:0] w_mem_idx;
  logic [3:0]    w_mem_strb;
  logic [31:0]   w_mem_wdata;

  // The sweep owns the write port while clearing; requests are blocked then.
  always_comb begin
    if (w_clearing) begin
      w_mem_we    = 1'b1;
      w_mem_idx   = r_clr_cnt;
      w_mem_strb  = 4'b1111;
      w_mem_wdata = '0;
    end else begin
      w_mem_we    = w_accept && req_we && !w_misal;
      w_mem_idx   = w_idx;
      w_mem_strb  = w_strb;
      w_mem_wdata = w_wdata_rep;
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_mem_strb[i]) begin
          r_mem[w_mem_idx][i*8 +: 8] <= w_mem_wdata[i*8 +: 8];
        end
      end
    end
    if (w_accept && !req_we) begin
      r_rd_word <= r_mem[w_idx];
    end
  end

  // ---------------------------------------------------------- response stage 1
  logic       r_s1_valid;
  logic       r_s1_err;
  logic       r_s1_load;
  logic [1:0] r_s1_size;
  logic [1:0] r_s1_off;
  logic       r_s1_uns;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_err   <= 1'b0;
      r_s1_load  <= 1'b0;
      r_s1_size  <= 2'b00;
      r_s1_off   <= 2'b00;
      r_s1_uns   <= 1'b0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_err  <= w_misal;
        r_s1_load <= !req_we;
        r_s1_size <= req_size;
        r_s1_off  <= w_off;
        r_s1_uns  <= req_unsigned;
      end
    end
  end

  logic [7:0]  w_lane_b;
  logic [15:0] w_lane_h;
  logic [31:0] w_fmt_rdata;
  logic        w_fmt_err;

  always_comb begin
    w_lane_b    = r_rd_word[{r_s1_off, 3'b000} +: 8];
    w_lane_h    = r_s1_off[1] ? r_rd_word[31:16] : r_rd_word[15:0];
    w_fmt_rdata = '0;
    w_fmt_err   = r_s1_valid && r_s1_err;
    if (r_s1_valid && r_s1_load && !r_s1_err) begin
      case (r_s1_size)
        c_SZ_BYTE: w_fmt_rdata = {{24{!r_s1_uns && w_lane_b[7]}}, w_lane_b};
        c_SZ_HALF: w_fmt_rdata = {{16{!r_s1_uns && w_lane_h[15]}}, w_lane_h};
        c_SZ_WORD: w_fmt_rdata = r_rd_word;
        default:   w_fmt_rdata = '0;
      endcase
    end
  end

  // -------------------------------------------------------------- output stage
  // Any LAT other than 1 builds the two-cycle pipeline.
  if (LAT == 1) begin : g_lat1
    assign rsp_valid = r_s1_valid;
    assign rsp_rdata = w_fmt_rdata;
    assign rsp_err   = w_fmt_err;
  end else begin : g_lat2
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_rsp_valid <= 1'b0;
        r_rsp_rdata <= '0;
        r_rsp_err   <= 1'b0;
      end else begin
        r_rsp_valid <= r_s1_valid;
        r_rsp_rdata <= w_fmt_rdata;
        r_rsp_err   <= w_fmt_err;
      end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
  end

endmodule

`default_nettype wire
